key_extractor: RTL
==================

// Module: key_extractor
// PURPOSE
//  Match-key builder sitting directly upstream of each stage's TCAM lookup engine.
//  Per-packet key-config selection: a 4-bit index in the PHV metadata picks one of 16 entries.
//  Per entry: gathers two 6B, two 4B and two 2B PHV containers into a left-aligned match key.
//  Also evaluates one 4B-vs-4B predicate, output as cond_flag.
//  Fully pipelined with fixed latency; the PHV travels alongside the key.
// PARAMETERS
//  PHV_LEN   1024  PHV width: [1023:640] 8x48b C6[7..0]; [639:384] 8x32b C4[7..0];
//                  [383:256] 8x16b C2[7..0]; [255:0] metadata. Container 7 = MSB slice.
//  KEY_LEN   896   output key width; must be >= 192
//  STAGE     0     stage number, informational only (no effect on logic)
// PORTS
//  axis_clk         in   1        sole clock
//  aresetn          in   1        async reset, active-HIGH (asserted = 1); port name per codebase
//  phv_in           in   PHV_LEN  packet header vector
//  phv_in_valid     in   1        phv_in qualifier; one PHV accepted per valid cycle
//  extract_key      out  KEY_LEN  match key to lookup engine
//  key_valid        out  1        one-cycle pulse qualifying extract_key/cond_flag/pkt_hdr_vec
//  cond_flag        out  1        predicate result
//  pkt_hdr_vec      out  PHV_LEN  PHV aligned with extract_key
//  key_cfg_wr_en    in   1        config write strobe
//  key_cfg_wr_addr  in   4        config entry address
//  key_cfg_wr_data  in   27       config entry data (layout below)
// BEHAVIOUR
//  Config entry (27b):
//  - [26:24] i6a, [23:21] i6b
//  - [20:18] i4a, [17:15] i4b
//  - [14:12] i2a, [11:9] i2b
//  - [8] cond_en, [7:6] op, [5:3] ca, [2:0] cb
//  Config table: 16 x 27b flops, all cleared by reset.
//  - Written on any cycle with key_cfg_wr_en=1.
//  - Config index = phv_in[255:252].
//  Pipeline: 2 cycles, no backpressure, no bubbles.
//  - C0 (phv_in_valid=1): register PHV and the selected config entry.
//  - C1: register key, cond_flag, PHV; key_valid=1.
//  - PHV at edge N -> outputs valid after edge N+2, with key_valid high for exactly one cycle.
//  - Back-to-back valids produce back-to-back outputs.
//  - Downstream must tolerate the input rate; spacing is the upstream's responsibility.
//  Key layout:
//  - extract_key[KEY_LEN-1 -: 192] = {C6[i6a],C6[i6b],C4[i4a],C4[i4b],C2[i2a],C2[i2b]}.
//  - Remaining LSBs are 0.
//  Predicate (unsigned):
//  - op 00: C4[ca]==C4[cb]; 01: >; 10: <; 11: !=.
//  - cond_en=0 forces cond_flag=1.
//  Config write/read collision:
//  - Write to entry X in the same cycle a PHV selects X: the PHV uses the OLD entry.
//  - The new entry applies from the next PHV onward.
//  - Writes never disturb PHVs already in flight.
//  Outputs are held when idle:
//  - extract_key, cond_flag and pkt_hdr_vec keep their last values while key_valid=0.
//  - Only key_valid returns to 0.
//  Reset (any time, including mid-flight):
//  - All outputs go to 0 immediately: key_valid, cond_flag, extract_key, pkt_hdr_vec.
//  - In-flight PHVs are discarded, never emitted after reset release.
//  - Config table is cleared. Entry 0 = all indices 0 and cond off.
//  - First valid after release behaves normally.
// TESTING
//  1. Reset, no writes; PHV with C6[0]=48'hA1, C4[0]=32'hB2, C2[0]=16'hC3, cfg idx 0, valid 1 cycle
//     -> 2 edges later key_valid=1 for 1 cycle;
//        key top 192b = {A1,A1,B2,B2,C3,C3} zero-extended per field;
//        LSBs 0; cond_flag=1.
//  2. Write entry 5 = {7,0,3,1,6,2,1,01,2,4}; PHV idx 5 with C4[2]=10, C4[4]=9
//     -> key = {C6[7],C6[0],C4[3],C4[1],C2[6],C2[2]}; cond_flag=1.
//     Repeat with C4[2]=9 -> cond_flag=0.
//  3. Four back-to-back valid PHVs with distinct idx/contents
//     -> four consecutive key_valid cycles, in order, each key/PHV pair matching its own input.
//  4. Write entry 3 in the same cycle as a PHV selecting 3 -> that PHV uses the old entry 3;
//     next PHV on idx 3 uses the new entry.
//  5. Assert aresetn one cycle after a valid PHV -> key_valid never pulses for it;
//     all outputs 0; after release, entry 3 reads back as zero config (key from C*[0]).
//  6. op sweep 00/01/10/11 with C4[ca]=C4[cb]=32'hFFFF_FFFF
//     -> cond_flag = 1,0,0,0; repeat with ca=5 vs cb=0 values 0 vs 1 -> 0,0,1,1.

Source files
------------

// File: rtl/key_extractor_if.sv
// rtl/key_extractor_if.sv - PHV, match-key and config-write bundle for key_extractor
interface key_extractor_if #(
  parameter int PHV_LEN = 1024,
  parameter int KEY_LEN = 896
);
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic [KEY_LEN-1:0] extract_key;
  logic               key_valid;
  logic               cond_flag;
  logic [PHV_LEN-1:0] pkt_hdr_vec;
  logic               key_cfg_wr_en;
  logic [3:0]         key_cfg_wr_addr;
  logic [26:0]        key_cfg_wr_data;

  // Upstream parser / control plane side
  modport master (
    output phv_in, phv_in_valid, key_cfg_wr_en, key_cfg_wr_addr, key_cfg_wr_data,
    input  extract_key, key_valid, cond_flag, pkt_hdr_vec
  );

  // Key extractor side
  modport slave (
    input  phv_in, phv_in_valid, key_cfg_wr_en, key_cfg_wr_addr, key_cfg_wr_data,
    output extract_key, key_valid, cond_flag, pkt_hdr_vec
  );
endinterface

// File: rtl/key_extractor.sv
// rtl/key_extractor.sv - two-stage TCAM match-key builder with per-packet config select
module key_extractor #(
  parameter int PHV_LEN = 1024,
  parameter int KEY_LEN = 896,
  parameter int STAGE   = 0
) (
  input  logic           axis_clk,
  input  logic           aresetn,
  key_extractor_if.slave bus
);
  localparam int C6_BASE = 640;
  localparam int C4_BASE = 384;
  localparam int C2_BASE = 256;

  // Container layout is hard-wired to a 1024b PHV; the key must hold all six fields.
  if (KEY_LEN < 192) begin : g_key_len_check
    $error("key_extractor: KEY_LEN must be at least 192");
  end
  if (PHV_LEN != 1024 || STAGE < 0) begin : g_phv_len_check
    $error("key_extractor: PHV_LEN must be 1024 and STAGE non-negative");
  end

  logic [26:0]        r_cfg [16];
  logic               r_s0_valid;
  logic [PHV_LEN-1:0] r_s0_phv;
  logic [26:0]        r_s0_cfg;
  logic               r_key_valid;
  logic               r_cond_flag;
  logic [KEY_LEN-1:0] r_key;
  logic [PHV_LEN-1:0] r_phv;

  logic [47:0]        w_c6 [8];
  logic [31:0]        w_c4 [8];
  logic [15:0]        w_c2 [8];
  logic [KEY_LEN-1:0] w_key;
  logic               w_cond;
  logic [31:0]        w_ca;
  logic [31:0]        w_cb;

  // Split the stage-0 PHV into its container arrays (container 7 is the MSB slice).
  for (genvar g = 0; g < 8; g++) begin : g_cont
    assign w_c6[g] = r_s0_phv[C6_BASE + 48*g +: 48];
    assign w_c4[g] = r_s0_phv[C4_BASE + 32*g +: 32];
    assign w_c2[g] = r_s0_phv[C2_BASE + 16*g +: 16];
  end

  // Config table: written by the control plane, cleared by reset.
  always_ff @(posedge axis_clk or posedge aresetn) begin
    if (aresetn) begin
      for (int i = 0; i < 16; i++) r_cfg[i] <= '0;
    end else if (bus.key_cfg_wr_en) begin
      r_cfg[bus.key_cfg_wr_addr] <= bus.key_cfg_wr_data;
    end
  end

  // Stage 0: capture PHV and its config entry; a same-cycle write is not yet visible here.
  always_ff @(posedge axis_clk or posedge aresetn) begin
    if (aresetn) begin
      r_s0_valid <= 1'b0;
      r_s0_phv   <= '0;
      r_s0_cfg   <= '0;
    end else begin
      r_s0_valid <= bus.phv_in_valid;
      if (bus.phv_in_valid) begin
        r_s0_phv <= bus.phv_in;
        r_s0_cfg <= r_cfg[bus.phv_in[255:252]];
      end
    end
  end

  // Left-aligned key: six selected containers on top, zero padding below.
  always_comb begin
    w_key = '0;
    w_key[KEY_LEN-1 -: 192] = {w_c6[r_s0_cfg[26:24]], w_c6[r_s0_cfg[23:21]],
                               w_c4[r_s0_cfg[20:18]], w_c4[r_s0_cfg[17:15]],
                               w_c2[r_s0_cfg[14:12]], w_c2[r_s0_cfg[11:9]]};
  end

  assign w_ca = w_c4[r_s0_cfg[5:3]];
  assign w_cb = w_c4[r_s0_cfg[2:0]];

  // Unsigned 4B predicate; a disabled predicate always reports true.
  always_comb begin
    w_cond = 1'b1;
    if (r_s0_cfg[8]) begin
      case (r_s0_cfg[7:6])
        2'b00:   w_cond = (w_ca == w_cb);
        2'b01:   w_cond = (w_ca >  w_cb);
        2'b10:   w_cond = (w_ca <  w_cb);
        default: w_cond = (w_ca != w_cb);
      endcase
    end
  end

  // Stage 1: register results; data outputs hold their last value between pulses.
  always_ff @(posedge axis_clk or posedge aresetn) begin
    if (aresetn) begin
      r_key_valid <= 1'b0;
      r_cond_flag <= 1'b0;
      r_key       <= '0;
      r_phv       <= '0;
    end else begin
      r_key_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_cond_flag <= w_cond;
        r_key       <= w_key;
        r_phv       <= r_s0_phv;
      end
    end
  end

  assign bus.key_valid   = r_key_valid;
  assign bus.cond_flag   = r_cond_flag;
  assign bus.extract_key = r_key;
  assign bus.pkt_hdr_vec = r_phv;
endmodule
